cjg_mem_ctrl: RTL and testbench

Synthesizable, parametrised memory controller for the cjg_risc core: a single shared word array with byte-addressed, little-endian storage, serving an instruction-fetch port (read-only) and a data port (read/write with byte enables). It adds configurable wait states, a req/ack handshake, round-robin arbitration, and misaligned/out-of-range error reporting. It sits between the core's `pm_*`/`dm_*` interfaces and on-chip storage.

---
 rtl/cjg_mem_pkg.sv | 9 +
 rtl/cjg_mem_array.sv | 23 ++
 rtl/cjg_mem_ctrl.sv | 84 ++++++++
 tb/tb_cjg_mem_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cjg_mem_pkg.sv
// cjg_mem_pkg: shared FSM states, port ids and lane helper for the cjg_risc memory controller
package cjg_mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;
   function automatic int BYTES(input int data_w);
      return data_w / 8;
   endfunction
endpackage

// File: rtl/cjg_mem_array.sv
// cjg_mem_array: word storage with per-lane byte-enable write and registered read on the same edge
module cjg_mem_array import cjg_mem_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int DEPTH_WORDS = 16384
) (
   input  logic                           clk,
   input  logic                           en,
   input  logic                           we,
   input  logic [DATA_W/8-1:0]            be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [DATA_W-1:0]              wdata,
   output logic [DATA_W-1:0]              rdata
);
   localparam int NB = BYTES(DATA_W);
   logic [DATA_W-1:0] mem [DEPTH_WORDS];
   always_ff @(posedge clk)
      if (en) begin
         if (we)
            for (int i = 0; i < NB; i++)
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         rdata <= mem[addr];
      end
endmodule

// File: rtl/cjg_mem_ctrl.sv
// cjg_mem_ctrl: two-port (fetch/data) arbitrated memory controller with wait states and error reporting
module cjg_mem_ctrl import cjg_mem_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int DEPTH_WORDS = 16384,
   parameter int WAIT_STATES = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_ack,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_ack,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err
);
   localparam int NB = BYTES(DATA_W);
   localparam int LB = $clog2(NB);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH_WORDS * NB);
   localparam logic [2:0] CNT_INIT = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
   state_t state, next;
   logic [2:0] cnt;
   logic last, port, we_r, err_r, any_req, grant, err_in, mem_en;
   logic [NB-1:0] be_r;
   logic [ADDR_W-1:0] addr_r, a_in;
   logic [DATA_W-1:0] wdata_r, q;
   always_comb begin
      any_req = i_req | d_req;
      grant = (d_req && (!i_req || last == PORT_I)) ? PORT_D : PORT_I;
      a_in = grant == PORT_D ? d_addr : i_addr;
      err_in = (a_in & ADDR_W'(NB - 1)) != '0 || {1'b0, a_in} >= LIMIT;
      next = state == IDLE ? (any_req ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE)
           : state == WAIT ? (cnt == 3'd0 ? RESP : WAIT)
           : IDLE;
      // reset on the commit edge must suppress the write
      mem_en = state == RESP && !err_r && !reset;
   end
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         last <= PORT_I;
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         i_err <= 1'b0;
         d_err <= 1'b0;
      end else begin
         state <= next;
         i_ack <= state == RESP && port == PORT_I;
         d_ack <= state == RESP && port == PORT_D;
         i_err <= state == RESP && port == PORT_I && err_r;
         d_err <= state == RESP && port == PORT_D && err_r;
         if (state == IDLE && any_req) begin
            cnt <= CNT_INIT;
            last <= grant;
            port <= grant;
            addr_r <= a_in;
            we_r <= grant == PORT_D && d_we;
            be_r <= d_be;
            wdata_r <= d_wdata;
            err_r <= err_in;
         end else if (state == WAIT)
            cnt <= cnt - 3'd1;
      end
   cjg_mem_array #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk(clk),
      .en(mem_en),
      .we(we_r),
      .be(be_r),
      .addr(AW'(addr_r >> LB)),
      .wdata(wdata_r),
      .rdata(q)
   );
   assign i_rdata = (i_ack && !i_err) ? q : '0;
   assign d_rdata = (d_ack && !d_err && !we_r) ? q : '0;
endmodule

// File: tb/tb_cjg_mem_ctrl.sv
// tb_cjg_mem_ctrl: directed checks of three controller instances (0, 2 and 3 wait states, 256 words)
module tb_cjg_mem_ctrl;
   logic clk = 1'b0;
   logic reset [3], i_req [3], d_req [3], d_we [3];
   logic i_ack [3], i_err [3], d_ack [3], d_err [3];
   logic [15:0] i_addr [3], d_addr [3];
   logic [3:0] d_be [3];
   logic [31:0] d_wdata [3], i_rdata [3], d_rdata [3];
   int vec = 0, errs = 0;
   always #5 clk = ~clk;
   for (genvar k = 0; k < 3; k++) begin : g_dut
      cjg_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(k == 0 ? 0 : k + 1)) u (
         .clk(clk), .reset(reset[k]),
         .i_req(i_req[k]), .i_addr(i_addr[k]), .i_ack(i_ack[k]), .i_rdata(i_rdata[k]), .i_err(i_err[k]),
         .d_req(d_req[k]), .d_we(d_we[k]), .d_be(d_be[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
         .d_ack(d_ack[k]), .d_rdata(d_rdata[k]), .d_err(d_err[k])
      );
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic access(input int n, input logic port, input logic we, input logic [3:0] be,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rd, output logic er);
      if (port) begin
         d_req[n] = 1'b1; d_we[n] = we; d_be[n] = be; d_addr[n] = addr; d_wdata[n] = wdata;
      end else begin
         i_req[n] = 1'b1; i_addr[n] = addr;
      end
      lat = 99; rd = 'x; er = 1'bx;
      for (int c = 1; c <= 20 && lat == 99; c++) begin
         tick();
         if (port ? d_ack[n] : i_ack[n]) begin
            lat = c;
            rd = port ? d_rdata[n] : i_rdata[n];
            er = port ? d_err[n] : i_err[n];
         end
      end
      i_req[n] = 1'b0;
      d_req[n] = 1'b0;
   endtask
   initial begin
      int lat, t1, t2, acks;
      logic [31:0] rd;
      logic er;
      logic [1:0] arb_exp [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      for (int n = 0; n < 3; n++) begin
         reset[n] = 1'b1; i_req[n] = 1'b0; d_req[n] = 1'b0; d_we[n] = 1'b0;
         i_addr[n] = '0; d_addr[n] = '0; d_be[n] = '0; d_wdata[n] = '0;
      end
      tick(); tick();
      for (int n = 0; n < 3; n++) reset[n] = 1'b0;
      chk("reset_flags", {60'd0, i_ack[0], d_ack[0], i_err[0], d_err[0]}, 64'd0);
      chk("reset_rdata", {i_rdata[0], d_rdata[0]}, 64'd0);
      // zero wait states: basic write/read/fetch
      access(0, 1'b1, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, lat, rd, er);
      chk("wr10_lat", 64'(lat), 64'd2);
      chk("wr10_err_rdata", {31'd0, er, rd}, 64'd0);
      access(0, 1'b1, 1'b0, 4'hF, 16'h0010, 32'h0, lat, rd, er);
      chk("rd10_lat", 64'(lat), 64'd2);
      chk("rd10_data", {31'd0, er, rd}, {32'd0, 32'hDEADBEEF});
      access(0, 1'b0, 1'b0, 4'h0, 16'h0010, 32'h0, lat, rd, er);
      chk("if10_lat", 64'(lat), 64'd2);
      chk("if10_data", {31'd0, er, rd}, {32'd0, 32'hDEADBEEF});
      // byte lanes, little-endian
      access(0, 1'b1, 1'b1, 4'hF, 16'h0020, 32'h0, lat, rd, er);
      access(0, 1'b1, 1'b1, 4'b0010, 16'h0020, 32'h0000AB00, lat, rd, er);
      access(0, 1'b1, 1'b0, 4'hF, 16'h0020, 32'h0, lat, rd, er);
      chk("be_lane1", {31'd0, er, rd}, {32'd0, 32'h0000AB00});
      access(0, 1'b1, 1'b1, 4'b1000, 16'h0020, 32'h12000000, lat, rd, er);
      access(0, 1'b1, 1'b0, 4'hF, 16'h0020, 32'h0, lat, rd, er);
      chk("be_lane3", {31'd0, er, rd}, {32'd0, 32'h1200AB00});
      // errors
      access(0, 1'b1, 1'b1, 4'hF, 16'h0013, 32'h11111111, lat, rd, er);
      chk("mis_lat", 64'(lat), 64'd2);
      chk("mis_err", {31'd0, er, rd}, {31'd0, 1'b1, 32'd0});
      access(0, 1'b1, 1'b0, 4'hF, 16'h0010, 32'h0, lat, rd, er);
      chk("mis_nowrite", {31'd0, er, rd}, {32'd0, 32'hDEADBEEF});
      access(0, 1'b0, 1'b0, 4'h0, 16'h0400, 32'h0, lat, rd, er);
      chk("oob_lat", 64'(lat), 64'd2);
      chk("oob_err", {31'd0, er, rd}, {31'd0, 1'b1, 32'd0});
      access(0, 1'b0, 1'b0, 4'h0, 16'h03FC, 32'h0, lat, rd, er);
      chk("last_word_ok", {63'd0, er}, 64'd0);
      // arbitration: both held high, data wins the first tie
      i_addr[0] = 16'h0010; d_addr[0] = 16'h0020; d_we[0] = 1'b0;
      i_req[0] = 1'b1; d_req[0] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         chk($sformatf("arb_cycle%0d", c + 1), {62'd0, i_ack[0], d_ack[0]}, {62'd0, arb_exp[c]});
      end
      i_req[0] = 1'b0; d_req[0] = 1'b0;
      tick();
      // three wait states
      access(2, 1'b1, 1'b1, 4'hF, 16'h0010, 32'hAAAA5555, lat, rd, er);
      chk("ws3_wr_lat", 64'(lat), 64'd5);
      access(2, 1'b1, 1'b0, 4'hF, 16'h0010, 32'h0, lat, rd, er);
      chk("ws3_rd_lat", 64'(lat), 64'd5);
      chk("ws3_rd_data", {31'd0, er, rd}, {32'd0, 32'hAAAA5555});
      d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 16'h0010;
      t1 = 0; t2 = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (d_ack[2] && t1 == 0) t1 = c;
         else if (d_ack[2] && t2 == 0) t2 = c;
      end
      d_req[2] = 1'b0;
      chk("ws3_b2b_first", 64'(t1), 64'd5);
      chk("ws3_b2b_gap", 64'(t2 - t1), 64'd5);
      // two wait states: reset during WAIT of a write
      access(1, 1'b1, 1'b1, 4'hF, 16'h0030, 32'h11223344, lat, rd, er);
      chk("ws2_wr_lat", 64'(lat), 64'd4);
      d_req[1] = 1'b1; d_we[1] = 1'b1; d_be[1] = 4'hF; d_addr[1] = 16'h0030; d_wdata[1] = 32'hCAFEF00D;
      tick();
      reset[1] = 1'b1; d_req[1] = 1'b0;
      tick();
      reset[1] = 1'b0;
      chk("rst_flags", {60'd0, i_ack[1], d_ack[1], i_err[1], d_err[1]}, 64'd0);
      chk("rst_rdata", {i_rdata[1], d_rdata[1]}, 64'd0);
      acks = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         acks += int'(d_ack[1]);
      end
      chk("rst_no_ack", 64'(acks), 64'd0);
      access(1, 1'b1, 1'b0, 4'hF, 16'h0030, 32'h0, lat, rd, er);
      chk("rst_kept_word", {31'd0, er, rd}, {32'd0, 32'h11223344});
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
